// File: rtl/pipo_arb_pkg.sv
// Shared types for the PIPO write arbiter: FSM state encoding.
package pipo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pipo_reg.sv
// WIDTH-bit parallel-in/parallel-out holding register with load enable
// and asynchronous active-low clear.
module pipo_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipo_write_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters single-word writes into
// one shared PIPO register, with a one-cycle ack per completed write.
module pipo_write_arbiter
  import pipo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 4,
  localparam int IDXW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [IDXW-1:0]          owner
);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [IDXW-1:0]    ptr_q;
  logic [IDXW-1:0]    owner_q;
  logic               q_valid_q;
  logic               load;
  logic [WIDTH-1:0]   load_d;
  logic [IDXW-1:0]    pick_d;

  // First asserted request strictly after p, wrapping; p itself is checked last.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [IDXW-1:0]    p);
    logic [IDXW-1:0] w;
    logic            found;
    int              idx;
    w     = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(p) + i) % NUM_REQ;
      if (!found && r[idx]) begin
        w     = IDXW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDXW-1:0] i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDXW'(k) == i) v[k] = 1'b1;
    end
    return v;
  endfunction

  assign pick_d = rr_pick(req, ptr_q);

  // ptr_q holds the current winner while in GRANT/ACK.
  assign load   = (state_q == GRANT) && req[ptr_q];
  assign load_d = data_in[ptr_q*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      ptr_q     <= IDXW'(NUM_REQ - 1);
      owner_q   <= '0;
      q_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q   <= onehot(pick_d);
            ptr_q   <= pick_d;
            state_q <= GRANT;
          end else begin
            gnt_q <= '0;
          end
        end
        GRANT: begin
          if (req[ptr_q]) begin
            owner_q   <= ptr_q;
            q_valid_q <= 1'b1;
            ack_q     <= gnt_q;
            state_q   <= ACK;
          end else begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        ACK: begin
          ack_q   <= '0;
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= '0;
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  pipo_reg #(.WIDTH(WIDTH)) u_reg (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .d     (load_d),
    .q     (q)
  );

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign q_valid = q_valid_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_pipo_write_arbiter.sv
// Directed table-driven bench for pipo_write_arbiter (NUM_REQ=4, WIDTH=4).
module tb_pipo_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] data_in;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [3:0]  q;
  logic        q_valid;
  logic [1:0]  owner;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [3:0]  q;
    logic        qv;
    logic [1:0]  own;
  } vec_t;

  vec_t tbl[$];

  pipo_write_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .data_in (data_in),
    .gnt     (gnt),
    .ack     (ack),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [3:0] ea,
                         input logic [3:0] eq, input logic eqv, input logic [1:0] eo);
    chk({tag, ".gnt"},     32'(gnt),     32'(eg));
    chk({tag, ".ack"},     32'(ack),     32'(ea));
    chk({tag, ".q"},       32'(q),       32'(eq));
    chk({tag, ".q_valid"}, 32'(q_valid), 32'(eqv));
    chk({tag, ".owner"},   32'(owner),   32'(eo));
  endtask

  task automatic add(input logic [3:0] r, input logic [15:0] d, input logic [3:0] g,
                     input logic [3:0] a, input logic [3:0] qq, input logic qv,
                     input logic [1:0] o);
    vec_t v;
    v.req = r; v.din = d; v.gnt = g; v.ack = a; v.q = qq; v.qv = qv; v.own = o;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Round-robin from reset: each requester drops req in its IDLE cycle after ack.
    add(4'b1111, 16'h8421, 4'b0001, 4'b0000, 4'h0, 1'b0, 2'd0);
    add(4'b1111, 16'h8421, 4'b0001, 4'b0001, 4'h1, 1'b1, 2'd0);
    add(4'b1111, 16'h8421, 4'b0000, 4'b0000, 4'h1, 1'b1, 2'd0);
    add(4'b1110, 16'h8421, 4'b0010, 4'b0000, 4'h1, 1'b1, 2'd0);
    add(4'b1111, 16'h8421, 4'b0010, 4'b0010, 4'h2, 1'b1, 2'd1);
    add(4'b1111, 16'h8421, 4'b0000, 4'b0000, 4'h2, 1'b1, 2'd1);
    add(4'b1101, 16'h8421, 4'b0100, 4'b0000, 4'h2, 1'b1, 2'd1);
    add(4'b1111, 16'h8421, 4'b0100, 4'b0100, 4'h4, 1'b1, 2'd2);
    add(4'b1111, 16'h8421, 4'b0000, 4'b0000, 4'h4, 1'b1, 2'd2);
    add(4'b1011, 16'h8421, 4'b1000, 4'b0000, 4'h4, 1'b1, 2'd2);
    add(4'b1111, 16'h8421, 4'b1000, 4'b1000, 4'h8, 1'b1, 2'd3);
    add(4'b1111, 16'h8421, 4'b0000, 4'b0000, 4'h8, 1'b1, 2'd3);
    add(4'b0111, 16'h8421, 4'b0001, 4'b0000, 4'h8, 1'b1, 2'd3);
    add(4'b1111, 16'h8421, 4'b0001, 4'b0001, 4'h1, 1'b1, 2'd0);
    add(4'b0000, 16'h8421, 4'b0000, 4'b0000, 4'h1, 1'b1, 2'd0);
    // Single request from requester 2.
    add(4'b0100, 16'h0B00, 4'b0100, 4'b0000, 4'h1, 1'b1, 2'd0);
    add(4'b0100, 16'h0B00, 4'b0100, 4'b0100, 4'hB, 1'b1, 2'd2);
    add(4'b0000, 16'h0B00, 4'b0000, 4'b0000, 4'hB, 1'b1, 2'd2);
    // Load 1001, then abort requester 1, then 0 wins before 1.
    add(4'b1000, 16'h9000, 4'b1000, 4'b0000, 4'hB, 1'b1, 2'd2);
    add(4'b1000, 16'h9000, 4'b1000, 4'b1000, 4'h9, 1'b1, 2'd3);
    add(4'b0000, 16'h9000, 4'b0000, 4'b0000, 4'h9, 1'b1, 2'd3);
    add(4'b0010, 16'h00F0, 4'b0010, 4'b0000, 4'h9, 1'b1, 2'd3);
    add(4'b0000, 16'h00F0, 4'b0000, 4'b0000, 4'h9, 1'b1, 2'd3);
    add(4'b0011, 16'h00F5, 4'b0001, 4'b0000, 4'h9, 1'b1, 2'd3);
    add(4'b0011, 16'h00F5, 4'b0001, 4'b0001, 4'h5, 1'b1, 2'd0);
    add(4'b0010, 16'h00F5, 4'b0000, 4'b0000, 4'h5, 1'b1, 2'd0);
    add(4'b0010, 16'h00F5, 4'b0010, 4'b0000, 4'h5, 1'b1, 2'd0);
    add(4'b0010, 16'h00F5, 4'b0010, 4'b0010, 4'hF, 1'b1, 2'd1);
    add(4'b0000, 16'h00F5, 4'b0000, 4'b0000, 4'hF, 1'b1, 2'd1);

    reset   = 1'b0;
    req     = '0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_hold", 4'b0000, 4'b0000, 4'h0, 1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk_all("post_reset_idle", 4'b0000, 4'b0000, 4'h0, 1'b0, 2'd0);

    foreach (tbl[i]) begin
      req     = tbl[i].req;
      data_in = tbl[i].din;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].ack, tbl[i].q, tbl[i].qv, tbl[i].own);
    end

    // Isolation: requester 3 writes 0110 while slices 0-2 churn.
    req     = 4'b1000;
    data_in = {4'h6, 12'($urandom)};
    tick();
    chk("iso_gnt", 32'(gnt), 32'h8);
    data_in = {4'h6, 12'($urandom)};
    tick();
    chk_all("iso_ack", 4'b1000, 4'b1000, 4'h6, 1'b1, 2'd3);
    req     = 4'b0000;
    data_in = {4'h6, 12'($urandom)};
    tick();
    chk_all("iso_done", 4'b0000, 4'b0000, 4'h6, 1'b1, 2'd3);

    // Reset pulse mid-ACK clears everything without waiting for a clock edge.
    req     = 4'b0001;
    data_in = 16'h000A;
    tick();
    tick();
    chk_all("pre_rst_ack", 4'b0001, 4'b0001, 4'hA, 1'b1, 2'd0);
    #1;
    reset = 1'b0;
    #1;
    chk_all("mid_ack_reset", 4'b0000, 4'b0000, 4'h0, 1'b0, 2'd0);
    req = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b0001;
    tick();
    chk_all("after_rst_gnt", 4'b0001, 4'b0000, 4'h0, 1'b0, 2'd0);
    tick();
    chk_all("after_rst_ack", 4'b0001, 4'b0001, 4'hA, 1'b1, 2'd0);
    req = 4'b0000;
    tick();

    // Random request run: grant/ack one-hot-or-zero, ack implies grant.
    for (int c = 0; c < 200; c++) begin
      req     = 4'($urandom_range(0, 15));
      data_in = 16'($urandom);
      tick();
      chk("onehot_props",
          32'($onehot0(gnt) && $onehot0(ack) && ((ack & ~gnt) == 4'b0000)), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
